csr_counter_rw: RTL and testbench
=================================

# csr_counter_rw

Machine-mode counter and scratch CSR bank of the RV32 CSR file. It is the consuming end of the CSR operand path: it takes the already-selected write operand (rs1 data or zero-extended uimm) and applies CSRRW/CSRRS/CSRRC read-modify-write to mscratch, mcountinhibit and the 64-bit mcycle/minstret counters. It returns the pre-write value for rd and flags accesses it cannot honour. The counters advance autonomously every clock and on every retire pulse.

## Interface
- No parameters.
- clk_in  input  1  clock; all state updates on rising edge
- rst_in  input  1  synchronous, active-high reset
- csr_addr_in  input  12  CSR address of the instruction in write-back
- csr_op_in  input  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; only [1:0] used here
- wr_en_in  input  1  CSR instruction valid this cycle
- pre_data_in  input  32  write operand, already muxed between rs1 and {27'b0,uimm}
- instret_inc_in  input  1  one instruction retired this cycle
- rd_data_out  output  32  current (pre-write) value of addressed CSR; 0 if unmapped
- illegal_csr_out  output  1  access not honoured by this block

## Operation
- Address map: mscratch 0x340; mcountinhibit 0x320; mcycle 0xB00; mcycleh 0xB80; minstret 0xB02; minstreth 0xB82. Read-only shadows: cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82.
- New value: RW → pre_data; RS → old | pre_data; RC → old & ~pre_data.
- Write intent: op[1:0]==01 always; RS/RC only when pre_data_in != 0 (no write, no side effect otherwise).
- Write commits only when wr_en_in=1, address writable, and write intent.
- illegal_csr_out = wr_en_in & (address unmapped | (address is read-only shadow & write intent)). An illegal access changes no state.
- mcountinhibit: only bit0 (CY) and bit2 (IR) are stored; all other bits read 0, and writes to them are ignored.
- mcycle: 64-bit counter, +1 per clock when CY=0. minstret: 64-bit counter, +1 when instret_inc_in=1 and IR=0.
- Full 64-bit add with carry from low into high. 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- A software write to either half of a counter suppresses that counter's increment in the same cycle. The written half takes the new value. The other half holds.
- rd_data_out is combinational from current registers for any address, including during an illegal write.

## Timing
- Reset: mscratch, mcountinhibit, and both counters all clear to 0. Counters start counting on the first cycle after rst_in deasserts. rd_data_out reflects 0 while in reset.
- rst_in has priority over writes and increments. Asserting it mid-operation zeroes state on the next edge.
- Write latency 1: a value written in cycle N is readable in cycle N+1. rd_data_out in cycle N shows the old value.
- A mcountinhibit write in cycle N first affects increments in cycle N+1. The increment in cycle N uses the old bits.
- Back-to-back CSR writes every cycle are supported. There is no handshake and no stall.

## Structure
- Shared package csr_pkg:
  - 12-bit address constants listed above.
  - funct3 encodings.
  - mcountinhibit bit indices CY=0, IR=2.
- Sub-module csr_counter64, instantiated twice (mcycle, minstret):
  - Inputs: clk_in, rst_in, inc_in, wr_lo_in, wr_hi_in, wdata_in[31:0].
  - Output: count_out[63:0].
  - Implements the write-suppresses-increment and wrap rules.
- Top level decodes the address, forms the read-modify-write value, muxes the read data and generates the illegal flag.

## Test plan
- Reset then idle 10 cycles → mcycle reads 10 (±1 for sample point); minstret 0; mscratch 0; illegal_csr_out 0.
- RW 0x340 with 0xDEAD_BEEF → rd_data_out 0 that cycle; next cycle reads 0xDEAD_BEEF. Then RC with 0x0000_00FF → next read 0xDEAD_BE00.
- RW mcycle=0xFFFF_FFFE, mcycleh=0xFFFF_FFFF → after 2 free cycles the counter reads 0x0000_0000_0000_0000; the high half carries correctly.
- RS 0x320 with 0x4, then pulse instret_inc_in 5 times → minstret unchanged. RC 0x320 with 0x4, then 3 pulses → minstret +3. Write-cycle increment uses the old inhibit.
- RW 0xC00 → illegal_csr_out=1 and no state change. RS 0xC00 with pre_data 0 → illegal_csr_out=0 and rd_data_out equals mcycle low. Address 0x7C0 → illegal_csr_out=1, rd_data_out 0.
- Write to minstret in the same cycle as instret_inc_in=1 → next cycle reads exactly the written value; assert rst_in mid-sequence → all reads 0 the next cycle.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode counter/scratch CSR bank:
// CSR addresses, funct3 encodings, mcountinhibit bit positions and the RMW helper.
package csr_pkg;

   localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
   localparam logic [11:0] CSR_CYCLE         = 12'hC00;
   localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
   localparam logic [11:0] CSR_INSTRET       = 12'hC02;
   localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

   localparam int MCI_CY = 0;
   localparam int MCI_IR = 2;

   typedef enum logic [2:0] {
      F3_RW  = 3'b001,
      F3_RS  = 3'b010,
      F3_RC  = 3'b011,
      F3_RWI = 3'b101,
      F3_RSI = 3'b110,
      F3_RCI = 3'b111
   } csr_funct3_e;

   typedef enum logic [1:0] {
      RMW_NONE = 2'b00,
      RMW_RW   = 2'b01,
      RMW_RS   = 2'b10,
      RMW_RC   = 2'b11
   } csr_rmw_e;

   function automatic logic [31:0] csr_rmw(input csr_rmw_e op,
                                           input logic [31:0] old_val,
                                           input logic [31:0] operand);
      logic [31:0] result;
      case (op)
         RMW_RW:  result = operand;
         RMW_RS:  result = old_val | operand;
         RMW_RC:  result = old_val & ~operand;
         default: result = old_val;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/csr_counter_rw_if.sv
// Write-back side CSR access bus: operation, address and operand in; read data and
// illegal flag out. The master drives the access, the slave is the CSR bank.
interface csr_counter_rw_if;
   logic [11:0] csr_addr_in;
   logic [2:0]  csr_op_in;
   logic        wr_en_in;
   logic [31:0] pre_data_in;
   logic        instret_inc_in;
   logic [31:0] rd_data_out;
   logic        illegal_csr_out;

   modport master (
      output csr_addr_in,
      output csr_op_in,
      output wr_en_in,
      output pre_data_in,
      output instret_inc_in,
      input  rd_data_out,
      input  illegal_csr_out
   );

   modport slave (
      input  csr_addr_in,
      input  csr_op_in,
      input  wr_en_in,
      input  pre_data_in,
      input  instret_inc_in,
      output rd_data_out,
      output illegal_csr_out
   );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
// A write to either half takes precedence over the increment for that cycle.
module csr_counter64 (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        inc_in,
   input  logic        wr_lo_in,
   input  logic        wr_hi_in,
   input  logic [31:0] wdata_in,
   output logic [63:0] count_out
);

   logic [31:0] lo_q;
   logic [31:0] hi_q;
   logic [32:0] lo_sum;

   // Carry out of the low half feeds the high half; all-ones wraps to zero.
   assign lo_sum = {1'b0, lo_q} + 33'd1;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         lo_q <= '0;
         hi_q <= '0;
      end else if (wr_lo_in || wr_hi_in) begin
         if (wr_lo_in) lo_q <= wdata_in;
         if (wr_hi_in) hi_q <= wdata_in;
      end else if (inc_in) begin
         lo_q <= lo_sum[31:0];
         hi_q <= hi_q + {31'b0, lo_sum[32]};
      end
   end

   assign count_out = {hi_q, lo_q};

endmodule

// File: rtl/csr_counter_rw.sv
// Machine-mode scratch, counter-inhibit and mcycle/minstret CSR bank: applies
// CSRRW/RS/RC to the selected register and returns the pre-write value.
module csr_counter_rw
   import csr_pkg::*;
(
   input  logic            clk_in,
   input  logic            rst_in,
   csr_counter_rw_if.slave csr
);

   logic [31:0] mscratch_q;
   logic        inh_cy_q;
   logic        inh_ir_q;
   logic [63:0] mcycle;
   logic [63:0] minstret;

   csr_rmw_e    rmw_op;
   logic        write_intent;
   logic        mapped;
   logic        writable;
   logic        read_only;
   logic [31:0] rd_val;
   logic [31:0] new_val;
   logic        commit;

   logic        wr_mscratch;
   logic        wr_minhibit;
   logic        wr_mcycle_lo;
   logic        wr_mcycle_hi;
   logic        wr_minstret_lo;
   logic        wr_minstret_hi;

   // funct3 values outside the six CSR encodings carry no write intent.
   always_comb begin
      rmw_op = RMW_NONE;
      case (csr.csr_op_in)
         F3_RW, F3_RWI: rmw_op = RMW_RW;
         F3_RS, F3_RSI: rmw_op = RMW_RS;
         F3_RC, F3_RCI: rmw_op = RMW_RC;
         default:       rmw_op = RMW_NONE;
      endcase
   end

   // Set/clear with a zero operand is a pure read with no side effect.
   assign write_intent = (rmw_op == RMW_RW) ||
                         (((rmw_op == RMW_RS) || (rmw_op == RMW_RC)) &&
                          (csr.pre_data_in != '0));

   always_comb begin
      rd_val    = '0;
      mapped    = 1'b1;
      writable  = 1'b0;
      read_only = 1'b0;
      case (csr.csr_addr_in)
         CSR_MSCRATCH: begin
            rd_val   = mscratch_q;
            writable = 1'b1;
         end
         CSR_MCOUNTINHIBIT: begin
            rd_val           = '0;
            rd_val[MCI_CY]   = inh_cy_q;
            rd_val[MCI_IR]   = inh_ir_q;
            writable         = 1'b1;
         end
         CSR_MCYCLE: begin
            rd_val   = mcycle[31:0];
            writable = 1'b1;
         end
         CSR_MCYCLEH: begin
            rd_val   = mcycle[63:32];
            writable = 1'b1;
         end
         CSR_MINSTRET: begin
            rd_val   = minstret[31:0];
            writable = 1'b1;
         end
         CSR_MINSTRETH: begin
            rd_val   = minstret[63:32];
            writable = 1'b1;
         end
         CSR_CYCLE: begin
            rd_val    = mcycle[31:0];
            read_only = 1'b1;
         end
         CSR_CYCLEH: begin
            rd_val    = mcycle[63:32];
            read_only = 1'b1;
         end
         CSR_INSTRET: begin
            rd_val    = minstret[31:0];
            read_only = 1'b1;
         end
         CSR_INSTRETH: begin
            rd_val    = minstret[63:32];
            read_only = 1'b1;
         end
         default: mapped = 1'b0;
      endcase
   end

   assign new_val = csr_rmw(rmw_op, rd_val, csr.pre_data_in);
   assign commit  = csr.wr_en_in && writable && write_intent;

   assign wr_mscratch    = commit && (csr.csr_addr_in == CSR_MSCRATCH);
   assign wr_minhibit    = commit && (csr.csr_addr_in == CSR_MCOUNTINHIBIT);
   assign wr_mcycle_lo   = commit && (csr.csr_addr_in == CSR_MCYCLE);
   assign wr_mcycle_hi   = commit && (csr.csr_addr_in == CSR_MCYCLEH);
   assign wr_minstret_lo = commit && (csr.csr_addr_in == CSR_MINSTRET);
   assign wr_minstret_hi = commit && (csr.csr_addr_in == CSR_MINSTRETH);

   assign csr.illegal_csr_out = csr.wr_en_in && (!mapped || (read_only && write_intent));
   assign csr.rd_data_out     = rst_in ? '0 : rd_val;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         mscratch_q <= '0;
         inh_cy_q   <= 1'b0;
         inh_ir_q   <= 1'b0;
      end else begin
         if (wr_mscratch) mscratch_q <= new_val;
         if (wr_minhibit) begin
            inh_cy_q <= new_val[MCI_CY];
            inh_ir_q <= new_val[MCI_IR];
         end
      end
   end

   // Increments see the inhibit bits as they stand before this cycle's write.
   csr_counter64 u_mcycle (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .inc_in    (!inh_cy_q),
      .wr_lo_in  (wr_mcycle_lo),
      .wr_hi_in  (wr_mcycle_hi),
      .wdata_in  (new_val),
      .count_out (mcycle)
   );

   csr_counter64 u_minstret (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .inc_in    (csr.instret_inc_in && !inh_ir_q),
      .wr_lo_in  (wr_minstret_lo),
      .wr_hi_in  (wr_minstret_hi),
      .wdata_in  (new_val),
      .count_out (minstret)
   );

endmodule

// File: tb/tb_csr_counter_rw.sv
// Bench for csr_counter_rw: directed CSR accesses with literal expectations, plus a
// per-cycle comparison against an architectural model of the CSR bank.
module tb_csr_counter_rw;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   csr_counter_rw_if bus ();

   csr_counter_rw dut (
      .clk_in (clk),
      .rst_in (rst),
      .csr    (bus)
   );

   always #5 clk = ~clk;

   // Architectural state of the CSR bank.
   logic [63:0] m_cycle;
   logic [63:0] m_instret;
   logic [31:0] m_scratch;
   logic        m_cy;
   logic        m_ir;
   bit          model_on = 1'b0;

   function automatic logic [31:0] model_read(input logic [11:0] a);
      case (a)
         12'h340:          return m_scratch;
         12'h320:          return {29'd0, m_ir, 1'b0, m_cy};
         12'hB00, 12'hC00: return m_cycle[31:0];
         12'hB80, 12'hC80: return m_cycle[63:32];
         12'hB02, 12'hC02: return m_instret[31:0];
         12'hB82, 12'hC82: return m_instret[63:32];
         default:          return 32'd0;
      endcase
   endfunction

   function automatic bit is_writable(input logic [11:0] a);
      return (a == 12'h340) || (a == 12'h320) || (a == 12'hB00) ||
             (a == 12'hB80) || (a == 12'hB02) || (a == 12'hB82);
   endfunction

   function automatic bit is_shadow(input logic [11:0] a);
      return (a == 12'hC00) || (a == 12'hC80) || (a == 12'hC02) || (a == 12'hC82);
   endfunction

   function automatic bit has_intent(input logic [2:0] op, input logic [31:0] pre);
      if (op == 3'b001 || op == 3'b101) return 1'b1;
      if (op == 3'b010 || op == 3'b110 || op == 3'b011 || op == 3'b111) return pre != 0;
      return 1'b0;
   endfunction

   function automatic logic model_illegal();
      bit mapped;
      mapped = is_writable(bus.csr_addr_in) || is_shadow(bus.csr_addr_in);
      return bus.wr_en_in &&
             (!mapped || (is_shadow(bus.csr_addr_in) && has_intent(bus.csr_op_in, bus.pre_data_in)));
   endfunction

   always @(posedge clk) begin
      logic [31:0] old, nv;
      logic [63:0] nc, ni;
      bit          do_wr;
      if (rst) begin
         m_cycle = 0; m_instret = 0; m_scratch = 0; m_cy = 0; m_ir = 0;
         model_on = 1'b1;
      end else if (model_on) begin
         old   = model_read(bus.csr_addr_in);
         do_wr = bus.wr_en_in && is_writable(bus.csr_addr_in) &&
                 has_intent(bus.csr_op_in, bus.pre_data_in);
         case (bus.csr_op_in[1:0])
            2'b01:   nv = bus.pre_data_in;
            2'b10:   nv = old | bus.pre_data_in;
            default: nv = old & ~bus.pre_data_in;
         endcase
         nc = m_cycle;
         ni = m_instret;
         if (do_wr && bus.csr_addr_in == 12'hB00)      nc = {m_cycle[63:32], nv};
         else if (do_wr && bus.csr_addr_in == 12'hB80) nc = {nv, m_cycle[31:0]};
         else if (!m_cy)                               nc = m_cycle + 1;
         if (do_wr && bus.csr_addr_in == 12'hB02)      ni = {m_instret[63:32], nv};
         else if (do_wr && bus.csr_addr_in == 12'hB82) ni = {nv, m_instret[31:0]};
         else if (bus.instret_inc_in && !m_ir)         ni = m_instret + 1;
         m_cycle   = nc;
         m_instret = ni;
         if (do_wr && bus.csr_addr_in == 12'h340) m_scratch = nv;
         if (do_wr && bus.csr_addr_in == 12'h320) begin
            m_cy = nv[0];
            m_ir = nv[2];
         end
      end
   end

   always @(negedge clk) begin
      logic [31:0] exp_rd;
      logic        exp_ill;
      if (model_on) begin
         exp_rd  = rst ? 32'd0 : model_read(bus.csr_addr_in);
         exp_ill = model_illegal();
         checks++;
         if (bus.rd_data_out !== exp_rd) begin
            errors++;
            $display("FAIL model_rd @%0t addr=%h: got %h expected %h",
                     $time, bus.csr_addr_in, bus.rd_data_out, exp_rd);
         end
         checks++;
         if (bus.illegal_csr_out !== exp_ill) begin
            errors++;
            $display("FAIL model_ill @%0t addr=%h: got %b expected %b",
                     $time, bus.csr_addr_in, bus.illegal_csr_out, exp_ill);
         end
      end
   end

   task automatic drive(input logic [11:0] a, input logic [2:0] op, input logic wen,
                        input logic [31:0] pre, input logic inc);
      bus.csr_addr_in    = a;
      bus.csr_op_in      = op;
      bus.wr_en_in       = wen;
      bus.pre_data_in    = pre;
      bus.instret_inc_in = inc;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic peek(input string name, input logic [11:0] a, input logic [31:0] exp);
      drive(a, 3'b001, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      lit(name, bus.rd_data_out, exp);
      lit({name, "_ill"}, {31'd0, bus.illegal_csr_out}, 32'd0);
      tick();
   endtask

   task automatic wchk(input string name, input logic [11:0] a, input logic [2:0] op,
                       input logic [31:0] pre, input logic inc, input bit chk_rd,
                       input logic [31:0] exp_rd, input logic exp_ill);
      drive(a, op, 1'b1, pre, inc);
      @(negedge clk);
      if (chk_rd) lit({name, "_rd"}, bus.rd_data_out, exp_rd);
      lit({name, "_ill"}, {31'd0, bus.illegal_csr_out}, {31'd0, exp_ill});
      tick();
      drive(12'h000, 3'b000, 1'b0, 32'd0, 1'b0);
   endtask

   initial begin
      drive(12'h000, 3'b000, 1'b0, 32'd0, 1'b0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Free-running mcycle after reset; everything else at zero.
      repeat (10) tick();
      peek("mcycle_10", 12'hB00, 32'd10);
      peek("minstret_0", 12'hB02, 32'd0);
      peek("mscratch_0", 12'h340, 32'd0);

      wchk("scratch_rw", 12'h340, 3'b001, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'd0, 1'b0);
      peek("scratch_after_rw", 12'h340, 32'hDEAD_BEEF);
      wchk("scratch_rc", 12'h340, 3'b011, 32'h0000_00FF, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      peek("scratch_after_rc", 12'h340, 32'hDEAD_BE00);

      // 64-bit wrap: the mcycleh write freezes the low half for that cycle.
      wchk("mcycle_lo_wr", 12'hB00, 3'b001, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'd17, 1'b0);
      wchk("mcycle_hi_wr", 12'hB80, 3'b001, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, 1'b0);
      peek("mcycle_lo_fe", 12'hB00, 32'hFFFF_FFFE);
      peek("mcycle_hi_ff", 12'hB80, 32'hFFFF_FFFF);
      peek("mcycle_lo_wrap", 12'hB00, 32'd0);
      peek("mcycle_hi_wrap", 12'hB80, 32'd0);

      // Inhibit IR: the write cycle still counts with the old inhibit.
      wchk("inh_set_ir", 12'h320, 3'b010, 32'h4, 1'b1, 1'b1, 32'd0, 1'b0);
      repeat (5) begin
         drive(12'h000, 3'b000, 1'b0, 32'd0, 1'b1);
         tick();
      end
      peek("minstret_inhibited", 12'hB02, 32'd1);
      peek("inh_readback", 12'h320, 32'h4);
      wchk("inh_clr_ir", 12'h320, 3'b011, 32'h4, 1'b1, 1'b1, 32'h4, 1'b0);
      repeat (3) begin
         drive(12'h000, 3'b000, 1'b0, 32'd0, 1'b1);
         tick();
      end
      peek("minstret_plus3", 12'hB02, 32'd4);
      wchk("inh_all_ones", 12'h320, 3'b001, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0, 1'b0);
      peek("inh_masked", 12'h320, 32'h5);
      repeat (3) tick();
      wchk("inh_clear", 12'h320, 3'b001, 32'h0, 1'b0, 1'b1, 32'h5, 1'b0);

      // Read-only shadows and unmapped addresses.
      wchk("shadow_rw", 12'hC00, 3'b001, 32'h123, 1'b0, 1'b0, 32'd0, 1'b1);
      wchk("shadow_rs0", 12'hC00, 3'b010, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);
      wchk("shadow_rsi0", 12'hC82, 3'b110, 32'h0, 1'b0, 1'b1, 32'd0, 1'b0);
      wchk("unmapped_rw", 12'h7C0, 3'b001, 32'h5, 1'b0, 1'b1, 32'd0, 1'b1);
      wchk("unmapped_rs0", 12'h7C0, 3'b010, 32'h0, 1'b0, 1'b1, 32'd0, 1'b1);

      // Software write wins over a same-cycle retire.
      wchk("minstret_wr", 12'hB02, 3'b001, 32'h55, 1'b1, 1'b1, 32'd4, 1'b0);
      peek("minstret_exact", 12'hB02, 32'h55);
      wchk("minstreth_wr", 12'hB82, 3'b001, 32'h1, 1'b1, 1'b1, 32'd0, 1'b0);
      peek("minstreth_rd", 12'hB82, 32'h1);
      peek("minstret_lo_held", 12'hB02, 32'h55);
      wchk("scratch_rwi", 12'h340, 3'b101, 32'h1F, 1'b0, 1'b1, 32'hDEAD_BE00, 1'b0);

      // Mid-run reset clears everything.
      drive(12'h340, 3'b001, 1'b0, 32'd0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      lit("rd_in_reset", bus.rd_data_out, 32'd0);
      tick();
      rst = 1'b0;
      peek("scratch_post_rst", 12'h340, 32'd0);
      peek("minstret_post_rst", 12'hB02, 32'd0);
      peek("mcycle_post_rst", 12'hB00, 32'd2);
      peek("minstreth_post_rst", 12'hB82, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
